// File: rtl/sram_stream_reader_if.sv
// SRAM read port plus downstream valid/ready stream for sram_stream_reader.
// The master modport is the reader; the slave modport is the SRAM/consumer side.
interface sram_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  sram_csen;
    logic                  sram_rd_en;
    logic [ADDR_WIDTH-1:0] sram_rd_addr;
    logic [DATA_WIDTH-1:0] sram_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output sram_csen, sram_rd_en, sram_rd_addr, m_valid, m_data, m_last,
        input  sram_rd_data, m_ready
    );

    modport slave (
        input  sram_csen, sram_rd_en, sram_rd_addr, m_valid, m_data, m_last,
        output sram_rd_data, m_ready
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Strided SRAM reader streaming words through a 2-entry prefetch FIFO with credit-based issue.
// Optional: define SRAM_STREAM_READER_STALL_CNT_EN to add the stall_cnt output.
module sram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
`ifdef SRAM_STREAM_READER_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    sram_stream_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic                  fifo_last_q [2];
    logic                  fifo_last_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [15:0]           stall_q, stall_d;

    logic       pop;
    logic       issue;
    logic [2:0] occ;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d         = state_q;
        addr_d          = addr_q;
        last_addr_d     = last_addr_q;
        remain_d        = remain_q;
        done_d          = 1'b0;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        stall_d         = stall_q;

        pop   = (count_q != 2'd0) && bus.m_ready;
        // Credits: buffered words plus the read returning this cycle, minus the word leaving.
        occ   = {1'b0, count_q} + {2'b00, inflight_q};
        issue = (state_q == ISSUE) && (occ < (3'd2 + {2'b00, pop}));

        inflight_d      = issue;
        inflight_last_d = issue && (remain_q == LEN_WIDTH'(1));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    stall_d = '0;
                    if (len != '0) begin
                        state_d  = ISSUE;
                        addr_d   = base_addr;
                        remain_d = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d      = addr_q + stride;
                    last_addr_d = addr_q;
                    remain_d    = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (inflight_q) begin
            fifo_data_d[wr_ptr_q] = bus.sram_rd_data;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

        if ((state_q != IDLE) && (count_q != 2'd0) && !bus.m_ready && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            last_addr_q     <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            // NOTE: the two FIFO entries are reset so m_data reads 0 out of reset.
            fifo_data_q     <= '{default: '0};
            fifo_last_q     <= '{default: 1'b0};
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            stall_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see the same pre-edge values.
            state_q         <= state_d;
            addr_q          <= addr_d;
            last_addr_q     <= last_addr_d;
            remain_q        <= remain_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            stall_q         <= stall_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign bus.sram_csen    = busy;
    assign bus.sram_rd_en   = issue;
    // The address register already points past the last issued read, so show the issued one when idle.
    assign bus.sram_rd_addr = issue ? addr_q : last_addr_q;
    assign bus.m_valid      = (count_q != 2'd0);
    assign bus.m_data       = fifo_data_q[rd_ptr_q];
    assign bus.m_last       = (count_q != 2'd0) && fifo_last_q[rd_ptr_q];

`ifdef SRAM_STREAM_READER_STALL_CNT_EN
    assign stall_cnt = stall_q;
`else
    logic unused_stall;
    assign unused_stall = ^stall_q;
`endif
endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: SRAM model plus a queue-based expected stream.
// Define SRAM_STREAM_READER_STALL_CNT_EN here as for the RTL to also check stall_cnt.
module tb_sram_stream_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [7:0] stride = '0;
    logic [8:0] len = '0;
    logic       busy;
    logic       done;
`ifdef SRAM_STREAM_READER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [7:0] mem [256];
    int errors = 0;
    int checks = 0;

    sram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) sif ();

    sram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .len       (len),
        .busy      (busy),
        .done      (done),
`ifdef SRAM_STREAM_READER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (sif.master)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (sif.sram_rd_en) sif.sram_rd_data <= mem[sif.sram_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always 1; 1: ready pattern 1,0,0,1,0,1...; 2: random ready.
    task automatic run_xfer(input logic [7:0] b, input logic [7:0] s, input int n,
                            input int mode, input bit poke);
        int  exp_addr[$];
        bit  pat[6];
        int  issued, accepted, stalls;
        bit  done_seen, prev_stall, prev_last;
        logic [7:0] prev_data;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < n; k++) exp_addr.push_back((int'(b) + k * int'(s)) % 256);
        issued = 0; accepted = 0; stalls = 0;
        done_seen = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;

        @(negedge clk);
        start = 1'b1; base_addr = b; stride = s; len = 9'(n); sif.m_ready = 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (poke && c == 2) begin
                start = 1'b1; base_addr = ~b; len = 9'd5;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       sif.m_ready = 1'b1;
                1:       sif.m_ready = pat[(c - 1) % 6];
                default: sif.m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("csen_eq_busy", 32'(sif.sram_csen), 32'(busy));
            if (c == 1) begin
                check("t1_busy", 32'(busy), 32'd1);
                check("t1_rd_en", 32'(sif.sram_rd_en), 32'd1);
                check("t1_rd_addr", 32'(sif.sram_rd_addr), 32'(b));
            end
            if (c == 2) check("t2_no_valid", 32'(sif.m_valid), 32'd0);
            if (c == 3 && mode == 0) check("t3_valid", 32'(sif.m_valid), 32'd1);
            if (sif.sram_rd_en) begin
                check("issue_in_range", 32'(issued < n), 32'd1);
                if (issued < n) check("rd_addr", 32'(sif.sram_rd_addr), 32'(exp_addr[issued]));
            end
            check("outstanding_le2", 32'((issued - accepted) <= 2), 32'd1);
            if (prev_stall) begin
                check("stall_valid", 32'(sif.m_valid), 32'd1);
                check("stall_data", 32'(sif.m_data), 32'(prev_data));
                check("stall_last", 32'(sif.m_last), 32'(prev_last));
            end
            if (done) begin
                check("done_busy", 32'(busy), 32'd0);
                check("done_count", 32'(accepted), 32'(n));
                if (mode == 0) check("done_cycle", 32'(c), 32'(n + 3));
                done_seen = 1'b1;
                break;
            end
            if (sif.m_valid && sif.m_ready) begin
                check("word_in_range", 32'(accepted < n), 32'd1);
                if (accepted < n) begin
                    check("m_data", 32'(sif.m_data), 32'(mem[exp_addr[accepted]]));
                    check("m_last", 32'(sif.m_last), 32'(accepted == n - 1));
                end
                accepted++;
            end
            if (sif.m_valid && !sif.m_ready) stalls++;
            if (sif.sram_rd_en) issued++;
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_data  = sif.m_data;
            prev_last  = sif.m_last;
        end
        check("done_seen", 32'(done_seen), 32'd1);
`ifdef SRAM_STREAM_READER_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
        @(negedge clk);
        #1;
        check("done_pulse_end", 32'(done), 32'd0);
    endtask

    initial begin
        sif.m_ready = 1'b1;
        sif.sram_rd_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        // Reset values
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_csen", 32'(sif.sram_csen), 32'd0);
        check("rst_rd_en", 32'(sif.sram_rd_en), 32'd0);
        check("rst_rd_addr", 32'(sif.sram_rd_addr), 32'd0);
        check("rst_valid", 32'(sif.m_valid), 32'd0);
        check("rst_data", 32'(sif.m_data), 32'd0);
        check("rst_last", 32'(sif.m_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sequential read with identity SRAM contents
        run_xfer(8'h10, 8'd1, 4, 0, 1'b0);

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Address wrap
        run_xfer(8'hFE, 8'd3, 3, 0, 1'b0);

        // Backpressure pattern
        run_xfer(8'($urandom), 8'($urandom), 6, 1, 1'b0);

        // Zero-length start
        @(negedge clk);
        start = 1'b1; base_addr = 8'h33; len = 9'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_rd_en", 32'(sif.sram_rd_en), 32'd0);
        check("len0_valid", 32'(sif.m_valid), 32'd0);
        @(negedge clk);
        #1;
        check("len0_done_clr", 32'(done), 32'd0);
        check("len0_busy2", 32'(busy), 32'd0);
        check("len0_rd_en2", 32'(sif.sram_rd_en), 32'd0);

        // Start while busy is ignored
        run_xfer(8'h80, 8'd5, 7, 0, 1'b1);

        // Random transfers with random backpressure
        for (int t = 0; t < 3; t++)
            run_xfer(8'($urandom), 8'($urandom), $urandom_range(1, 20), 2, 1'b0);

        // Reset during DRAIN with both FIFO entries full
        @(negedge clk);
        start = 1'b1; base_addr = 8'h20; stride = 8'd1; len = 9'd2; sif.m_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_valid", 32'(sif.m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_csen", 32'(sif.sram_csen), 32'd0);
        check("mid_rst_rd_en", 32'(sif.sram_rd_en), 32'd0);
        check("mid_rst_rd_addr", 32'(sif.sram_rd_addr), 32'd0);
        check("mid_rst_valid", 32'(sif.m_valid), 32'd0);
        check("mid_rst_data", 32'(sif.m_data), 32'd0);
        check("mid_rst_last", 32'(sif.m_last), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sif.m_ready = 1'b1;
        run_xfer(8'h40, 8'd2, 5, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
Read-side initiator for the single-port-pair Sram buffers in the LeNet accelerator datapath.
- Walks a strided address sequence and drives Sram rd_en/rd_addr/csen.
- Absorbs the SRAM's 1-cycle synchronous read latency.
- Streams the returned words downstream (e.g. to the conv/PE array) over a valid/ready interface with backpressure.
- Uses a 2-entry prefetch FIFO and credit control, so no word is ever lost or duplicated.

Parameters:
DATA_WIDTH, 8, SRAM word width and stream data width
ADDR_WIDTH, 8, SRAM address width; address arithmetic is modulo 2**ADDR_WIDTH
LEN_WIDTH, 9, width of the transfer length field; max length 2**LEN_WIDTH-1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a transfer; ignored while busy=1
base_addr  input  ADDR_WIDTH  first address, sampled when start is accepted
stride  input  ADDR_WIDTH  address increment per word, sampled with start
len  input  LEN_WIDTH  number of words to read, sampled with start
busy  output  1  high from the cycle after start acceptance until done
done  output  1  single-cycle pulse at transfer completion
sram_csen  output  1  Sram chip select; equals busy
sram_rd_en  output  1  Sram read enable
sram_rd_addr  output  ADDR_WIDTH  Sram read address
sram_rd_data  input  DATA_WIDTH  Sram read data; valid the cycle after sram_rd_en
m_valid  output  1  stream word valid
m_ready  input  1  downstream ready
m_data  output  DATA_WIDTH  stream word
m_last  output  1  high with the final word of the transfer

Behaviour:
- Reset: FSM=IDLE; FIFO empty; counters 0. busy, done, sram_csen, sram_rd_en, m_valid, m_last = 0. sram_rd_addr and m_data = 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE: on start with len != 0.
  - IDLE -> done pulse, stay IDLE: on start with len == 0. done=1 next cycle, busy stays 0, no SRAM access.
  - ISSUE -> DRAIN: when the last read has been issued.
  - DRAIN -> IDLE: when the last word is accepted (m_valid & m_ready & m_last). done pulses in the cycle after that acceptance, with busy=0 in that cycle.
- Issue rule (ISSUE state): sram_rd_en=1 iff fifo_count + inflight - pop < 2.
  - pop = m_valid & m_ready.
  - inflight = a read was issued in the previous cycle.
  - On each issue: addr <= addr + stride (wraps mod 2**ADDR_WIDTH); remaining <= remaining - 1.
- Capture: when inflight=1, sram_rd_data is pushed into the FIFO at the end of that cycle. Its last flag is set iff it is the len-th read.
- The FIFO never overflows. A push and a pop in the same cycle are both legal.
- Stream side:
  - m_valid = FIFO not empty.
  - m_data and m_last come from the FIFO head and are held stable while m_valid & !m_ready.
- Latency with start accepted at the edge ending cycle T:
  - T+1: sram_rd_en=1, sram_rd_addr=base_addr.
  - T+2: data on sram_rd_data.
  - T+3: m_valid=1.
- Throughput: 1 word/cycle sustained while m_ready=1.
- Backpressure: with m_ready=0, at most 2 reads are outstanding/buffered, then issue stalls.
- sram_rd_addr holds its last value when sram_rd_en=0.
- start while busy: ignored; parameters are not re-sampled.
- Reset mid-transfer: immediate return to reset values. In-flight SRAM data is discarded.

Optional Feature:
Macro SRAM_STREAM_READER_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], which counts cycles with m_valid=1 & m_ready=0 during a transfer.
  - Cleared on start acceptance and saturates at 16'hFFFF.
  - Holds its value after done; reset value 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- base=8'h10, stride=1, len=4, m_ready=1, SRAM preloaded mem[i]=i:
  - rd_addr 10,11,12,13 in cycles T+1..T+4; m_data 10..13 in T+3..T+6.
  - m_last with 13; done pulse at T+7.
- base=8'hFE, stride=3, len=3: addresses FE, 01, 04 (wrap); data matches SRAM contents; m_last on the 3rd word.
- len=6 with m_ready toggled 1,0,0,1,0,1...:
  - No word lost or duplicated.
  - Never more than 2 unaccepted reads.
  - m_data stable while stalled.
  - Macro defined: stall_cnt equals the number of stalled cycles.
- len=0 start: done pulses next cycle; busy, sram_rd_en and m_valid stay 0.
- start pulsed again mid-transfer with different base/len: ignored; the original sequence completes unchanged.
- rst_n asserted during DRAIN with 2 words buffered: all outputs return to 0 immediately. A new start after release runs a clean transfer from its base.
